// File: rtl/panel_pkg.sv
// Shared constants and FSM state encoding for the LED panel frame-buffer path.
// The animation generator and the UART receiver use the same constants.
package panel_pkg;

  localparam int AW    = 9;
  localparam int DW    = 48;
  localparam int DEPTH = 512;

  localparam logic [AW-1:0] ADDR_LAST = 9'd511;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SWEEP = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/panel_addr_seq.sv
// Animation address counter plus its one-cycle delayed write address/valid.
// Rests at the last address so the generator never sees address 0 while idle.
module panel_addr_seq #(
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          run,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] addr_q, addr_d;
  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;

  // Next address: 0 on start, +1 while sweeping, otherwise park at LAST.
  always_comb begin
    addr_d     = LAST;
    wr_valid_d = run;
    wr_addr_d  = addr_q;
    if (start) begin
      addr_d = {AW{1'b0}};
    end else if (run && (addr_q != LAST)) begin
      addr_d = addr_q + ONE;
    end else begin
      addr_d = LAST;
    end
  end

  // Counter and delayed write-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= LAST;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= LAST;
    end else begin
      addr_q     <= addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign addr     = addr_q;
  assign last     = (addr_q == LAST);
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;

endmodule

// File: rtl/panel_fb_sched.sv
// Frame-buffer write scheduler: arbitrates the frame RAM write port between
// full-frame animation sweeps and single host (UART) writes.
module panel_fb_sched #(
  parameter int AW    = panel_pkg::AW,
  parameter int DW    = panel_pkg::DW,
  parameter int DEPTH = panel_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sweep_en,
  input  logic          frame_tick,
  output logic [AW-1:0] anim_addr,
  input  logic [DW-1:0] anim_data,
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  output logic          host_ack,
  output logic          ram_we,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun,
  output logic [15:0]   frame_cnt
);

  import panel_pkg::*;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic          sweep_start;
  logic          host_grant;
  logic          seq_last;
  logic          seq_wr_valid;
  logic [AW-1:0] seq_wr_addr;

  assign sweep_start = (state_q == ST_IDLE) && frame_tick && sweep_en;
  // A sweep start always wins over a pending host write in the same cycle.
  assign host_grant  = (state_q == ST_IDLE) && host_req && !sweep_start && !rst;

  panel_addr_seq #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_addr_seq (
    .clk      (clk),
    .rst      (rst),
    .start    (sweep_start),
    .run      (state_q == ST_SWEEP),
    .addr     (anim_addr),
    .last     (seq_last),
    .wr_valid (seq_wr_valid),
    .wr_addr  (seq_wr_addr)
  );

  // Next state and flag values.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          state_d = ST_SWEEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (seq_last) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_SWEEP;
        end
      end
      ST_DRAIN: begin
        state_d     = ST_IDLE;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DRAIN);
    // Only an enabled tick that cannot be honoured counts as an overrun.
    overrun_d    = overrun_q || (frame_tick && sweep_en && (state_q != ST_IDLE));
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // RAM write-port mux; host writes are same-cycle, sweep writes lag the address by one.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = seq_wr_addr;
    ram_wdata = anim_data;
    host_ack  = 1'b0;
    if (host_grant) begin
      ram_we    = 1'b1;
      ram_waddr = host_addr;
      ram_wdata = host_data;
      host_ack  = 1'b1;
    end else if (seq_wr_valid && !rst) begin
      ram_we    = 1'b1;
      ram_waddr = seq_wr_addr;
      ram_wdata = anim_data;
    end else begin
      ram_we    = 1'b0;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
